// File: rtl/vc_route_compute_pkg.sv
// Shared types and encodings for the VC route-computation stage:
// flit types, direction codes, XY port indices and per-VC state.
package vc_route_compute_pkg;

  localparam int FLIT_TYPE_WIDTH = 2;

  localparam logic [1:0] FLIT_TYPE_HEADER      = 2'd0;
  localparam logic [1:0] FLIT_TYPE_BODY        = 2'd1;
  localparam logic [1:0] FLIT_TYPE_TAIL        = 2'd2;
  localparam logic [1:0] FLIT_TYPE_HEADER_TAIL = 2'd3;

  localparam int DIRECTION_NORTH = 0;
  localparam int DIRECTION_EAST  = 1;
  localparam int DIRECTION_SOUTH = 2;
  localparam int DIRECTION_WEST  = 3;

  localparam int XY_PORT_DIRECTION_INDEX_LOCAL = 0;
  localparam int XY_PORT_DIRECTION_INDEX_NORTH = 1;
  localparam int XY_PORT_DIRECTION_INDEX_EAST  = 2;
  localparam int XY_PORT_DIRECTION_INDEX_SOUTH = 3;
  localparam int XY_PORT_DIRECTION_INDEX_WEST  = 4;

  typedef enum logic [1:0] {
    VC_IDLE    = 2'd0,
    VC_PENDING = 2'd1,
    VC_ROUTED  = 2'd2
  } vc_state_e;

  function automatic logic is_header(input logic [FLIT_TYPE_WIDTH-1:0] t);
    return (t == FLIT_TYPE_HEADER) || (t == FLIT_TYPE_HEADER_TAIL);
  endfunction

  function automatic logic is_tail(input logic [FLIT_TYPE_WIDTH-1:0] t);
    return (t == FLIT_TYPE_TAIL) || (t == FLIT_TYPE_HEADER_TAIL);
  endfunction

endpackage

// File: rtl/routing_algorithm_xy.sv
// Dimension-ordered XY routing: resolve X first, then Y, else LOCAL.
// Purely combinational; emits a one-hot output port.
module routing_algorithm_xy
  import vc_route_compute_pkg::*;
#(
  parameter int DimensionXWidth     = 2,
  parameter int DimensionYWidth     = 2,
  parameter int NodeIdIncreaseXAxis = DIRECTION_EAST,
  parameter int NodeIdIncreaseYAxis = DIRECTION_SOUTH,
  parameter int NumberOfPorts       = 5
) (
  input  logic [DimensionXWidth-1:0] x_cur,
  input  logic [DimensionYWidth-1:0] y_cur,
  input  logic [DimensionXWidth-1:0] x_dst,
  input  logic [DimensionYWidth-1:0] y_dst,
  output logic [NumberOfPorts-1:0]   port
);

  int port_idx;

  always_comb begin
    port_idx = XY_PORT_DIRECTION_INDEX_LOCAL;
    if (x_dst != x_cur) begin
      // A larger X lies in the axis growth direction
      if ((x_dst > x_cur) == (NodeIdIncreaseXAxis == DIRECTION_EAST))
        port_idx = XY_PORT_DIRECTION_INDEX_EAST;
      else
        port_idx = XY_PORT_DIRECTION_INDEX_WEST;
    end else if (y_dst != y_cur) begin
      if ((y_dst > y_cur) == (NodeIdIncreaseYAxis == DIRECTION_SOUTH))
        port_idx = XY_PORT_DIRECTION_INDEX_SOUTH;
      else
        port_idx = XY_PORT_DIRECTION_INDEX_NORTH;
    end
    port = '0;
    port[port_idx] = 1'b1;
  end

endmodule

// File: rtl/vc_route_compute_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, pointer advances past the
// granted requester only when a grant is issued.
module vc_route_rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [PW-1:0] ptr_q;
  int            idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PW'(idx);
        gnt_vld_o  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      ptr_q <= '0;
    else if (gnt_vld_o)
      ptr_q <= (gnt_idx_o == PW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

endmodule

// File: rtl/vc_route_compute.sv
// Per-input-port route computation: arbitrates VCs with unrouted headers onto
// one shared XY router and holds each VC's one-hot port until its tail leaves.
module vc_route_compute
  import vc_route_compute_pkg::*;
#(
  parameter int NodeId                  = 0,
  parameter int DimensionXWidth         = 2,
  parameter int DimensionYWidth         = 2,
  parameter int NodeIdIncreaseXAxis     = DIRECTION_EAST,
  parameter int NodeIdIncreaseYAxis     = DIRECTION_SOUTH,
  parameter int NumberOfPorts           = 5,
  parameter int NumberOfVirtualChannels = 2,
  parameter int FlitWidth               = 64,
  parameter int DstXLsb                 = 0,
  parameter int DstYLsb                 = 2,
  localparam int NumVC = NumberOfVirtualChannels,
  localparam int PW    = (NumVC > 1) ? $clog2(NumVC) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [DimensionXWidth-1:0]         x_cur_i,
  input  logic [DimensionYWidth-1:0]         y_cur_i,
  input  logic [NumVC*FlitWidth-1:0]         flit_i,
  input  logic [NumVC*FLIT_TYPE_WIDTH-1:0]   flit_type_i,
  input  logic [NumVC-1:0]                   flit_valid_i,
  input  logic [NumVC-1:0]                   flit_read_i,
  output logic [NumVC-1:0]                   route_valid_o,
  output logic [NumVC*NumberOfPorts-1:0]     route_port_o,
  output logic [NumVC-1:0]                   protocol_err_o
);

  if (NodeId < 0 || NumVC < 1) begin : g_param_check
    $error("vc_route_compute: NodeId must be >= 0 and NumberOfVirtualChannels >= 1");
  end

  vc_state_e                 state_q   [NumVC];
  vc_state_e                 state_nxt [NumVC];
  logic [NumVC-1:0]          req_p0;
  logic [NumVC-1:0]          gnt_p0;
  logic [PW-1:0]             gnt_idx_p0;
  logic                      gnt_vld_p0;
  logic [NumVC-1:0]          perr_p0;
  logic [FlitWidth-1:0]      sel_flit_p0;
  logic [NumberOfPorts-1:0]  route_port_p0;
  logic                      unused_flit_bits;

  always_comb begin
    req_p0  = '0;
    perr_p0 = '0;
    for (int v = 0; v < NumVC; v++) begin
      state_nxt[v] = state_q[v];
      req_p0[v] = (state_q[v] == VC_PENDING) ||
                  ((state_q[v] == VC_IDLE) && flit_valid_i[v] &&
                   is_header(flit_type_i[v*FLIT_TYPE_WIDTH +: FLIT_TYPE_WIDTH]));
      perr_p0[v] = (state_q[v] == VC_IDLE) && flit_valid_i[v] &&
                   !is_header(flit_type_i[v*FLIT_TYPE_WIDTH +: FLIT_TYPE_WIDTH]);
    end
    // The grant is resolved in the same cycle a header arrives, so IDLE can jump straight to ROUTED
    for (int v = 0; v < NumVC; v++) begin
      case (state_q[v])
        VC_IDLE:
          if (gnt_p0[v])      state_nxt[v] = VC_ROUTED;
          else if (req_p0[v]) state_nxt[v] = VC_PENDING;
        VC_PENDING:
          if (gnt_p0[v])      state_nxt[v] = VC_ROUTED;
        VC_ROUTED:
          if (flit_read_i[v] &&
              is_tail(flit_type_i[v*FLIT_TYPE_WIDTH +: FLIT_TYPE_WIDTH]))
            state_nxt[v] = VC_IDLE;
        default:              state_nxt[v] = VC_IDLE;
      endcase
    end
  end

  vc_route_rr_arbiter #(.N(NumVC)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_p0),
    .gnt_o     (gnt_p0),
    .gnt_idx_o (gnt_idx_p0),
    .gnt_vld_o (gnt_vld_p0)
  );

  assign sel_flit_p0 = flit_i[gnt_idx_p0*FlitWidth +: FlitWidth];

  routing_algorithm_xy #(
    .DimensionXWidth     (DimensionXWidth),
    .DimensionYWidth     (DimensionYWidth),
    .NodeIdIncreaseXAxis (NodeIdIncreaseXAxis),
    .NodeIdIncreaseYAxis (NodeIdIncreaseYAxis),
    .NumberOfPorts       (NumberOfPorts)
  ) u_xy (
    .x_cur (x_cur_i),
    .y_cur (y_cur_i),
    .x_dst (sel_flit_p0[DstXLsb +: DimensionXWidth]),
    .y_dst (sel_flit_p0[DstYLsb +: DimensionYWidth]),
    .port  (route_port_p0)
  );

  assign unused_flit_bits = ^{sel_flit_p0, gnt_vld_p0};

  // p0 -> p1: latch the routed port into the granted VC's slot
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int v = 0; v < NumVC; v++) state_q[v] <= VC_IDLE;
      route_valid_o  <= '0;
      route_port_o   <= '0;
      protocol_err_o <= '0;
    end else begin
      for (int v = 0; v < NumVC; v++) begin
        state_q[v]       <= state_nxt[v];
        route_valid_o[v] <= (state_nxt[v] == VC_ROUTED);
        if (gnt_p0[v])
          route_port_o[v*NumberOfPorts +: NumberOfPorts] <= route_port_p0;
        else if (state_nxt[v] != VC_ROUTED)
          route_port_o[v*NumberOfPorts +: NumberOfPorts] <= '0;
      end
      protocol_err_o <= perr_p0;
    end
  end

endmodule

// File: tb/tb_vc_route_compute.sv
// Directed bench for vc_route_compute: table of single-packet routes plus
// hand-written multi-cycle sequences (reset, arbitration, long packet, errors).
module tb_vc_route_compute;

  localparam int NVC = 2;
  localparam int FW  = 64;
  localparam int NP  = 5;

  localparam logic [1:0] T_HDR  = 2'd0;
  localparam logic [1:0] T_BODY = 2'd1;
  localparam logic [1:0] T_TAIL = 2'd2;
  localparam logic [1:0] T_HT   = 2'd3;

  localparam logic [4:0] P_LOCAL = 5'b00001;
  localparam logic [4:0] P_NORTH = 5'b00010;
  localparam logic [4:0] P_EAST  = 5'b00100;
  localparam logic [4:0] P_SOUTH = 5'b01000;
  localparam logic [4:0] P_WEST  = 5'b10000;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic [1:0]          x_cur, y_cur;
  logic [NVC*FW-1:0]   flit;
  logic [NVC*2-1:0]    flit_type;
  logic [NVC-1:0]      flit_valid, flit_read;
  logic [NVC-1:0]      route_valid;
  logic [NVC*NP-1:0]   route_port;
  logic [NVC-1:0]      protocol_err;

  int n_cmp  = 0;
  int n_fail = 0;

  vc_route_compute dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .x_cur_i        (x_cur),
    .y_cur_i        (y_cur),
    .flit_i         (flit),
    .flit_type_i    (flit_type),
    .flit_valid_i   (flit_valid),
    .flit_read_i    (flit_read),
    .route_valid_o  (route_valid),
    .route_port_o   (route_port),
    .protocol_err_o (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         vc;
    logic [1:0] dx;
    logic [1:0] dy;
    logic [4:0] exp_port;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int port_of(input int v);
    return int'(route_port[v*NP +: NP]);
  endfunction

  task automatic set_front(input int v, input logic [1:0] t, input logic [1:0] dx,
                           input logic [1:0] dy);
    flit_type[v*2 +: 2] = t;
    flit[v*FW +: FW]    = {60'h0, dy, dx};
  endtask

  initial begin
    vecs[0] = '{0, 2'd3, 2'd1, P_EAST};
    vecs[1] = '{0, 2'd1, 2'd0, P_NORTH};
    vecs[2] = '{0, 2'd1, 2'd1, P_LOCAL};
    vecs[3] = '{1, 2'd2, 2'd2, P_EAST};
    vecs[4] = '{1, 2'd1, 2'd2, P_SOUTH};
    vecs[5] = '{1, 2'd0, 2'd0, P_WEST};
    vecs[6] = '{0, 2'd3, 2'd3, P_EAST};

    x_cur = 2'd1; y_cur = 2'd1;
    flit = '0; flit_type = '0; flit_valid = '0; flit_read = '0;

    // Reset held with headers on both VCs
    rst_ni = 1'b0;
    set_front(0, T_HDR, 2'd0, 2'd1);
    set_front(1, T_HDR, 2'd1, 2'd3);
    flit_valid = 2'b11;
    tick(); tick();
    chk("reset_valid", int'(route_valid), 0);
    chk("reset_port", int'(route_port), 0);
    chk("reset_err", int'(protocol_err), 0);

    // Release: VC0 wins first, VC1 one cycle later
    rst_ni = 1'b1;
    tick();
    chk("pair0_valid_t1", int'(route_valid), 2'b01);
    chk("pair0_vc0_west", port_of(0), int'(P_WEST));
    chk("pair0_vc1_idle_port", port_of(1), 0);
    tick();
    chk("pair0_valid_t2", int'(route_valid), 2'b11);
    chk("pair0_vc1_south", port_of(1), int'(P_SOUTH));
    chk("pair0_vc0_held", port_of(0), int'(P_WEST));
    flit_type = {T_TAIL, T_TAIL}; flit_read = 2'b11;
    tick();
    chk("pair0_retired", int'(route_valid), 0);
    flit_valid = '0; flit_read = '0;

    // Table of single header+tail packets
    for (int i = 0; i < 7; i++) begin
      int v;
      v = vecs[i].vc;
      set_front(v, T_HT, vecs[i].dx, vecs[i].dy);
      flit_valid[v] = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", i), int'(route_valid), 1 << v);
      chk($sformatf("vec%0d_port", i), port_of(v), int'(vecs[i].exp_port));
      flit_read[v] = 1'b1;
      tick();
      chk($sformatf("vec%0d_cleared", i), int'(route_valid), 0);
      chk($sformatf("vec%0d_port_cleared", i), port_of(v), 0);
      flit_read = '0; flit_valid = '0;
    end

    // Last grant was VC0, so the next simultaneous pair goes to VC1 first
    set_front(0, T_HT, 2'd3, 2'd1);
    set_front(1, T_HT, 2'd1, 2'd0);
    flit_valid = 2'b11;
    tick();
    chk("pair1_valid_t1", int'(route_valid), 2'b10);
    chk("pair1_vc1_north", port_of(1), int'(P_NORTH));
    tick();
    chk("pair1_valid_t2", int'(route_valid), 2'b11);
    chk("pair1_vc0_east", port_of(0), int'(P_EAST));
    flit_read = 2'b11;
    tick();
    chk("pair1_retired", int'(route_valid), 0);
    flit_read = '0; flit_valid = '0;

    // Long packet on VC1: header, 3 body, tail, then back-to-back header
    set_front(1, T_HDR, 2'd0, 2'd1);
    flit_valid[1] = 1'b1;
    tick();
    chk("long_hdr_valid", int'(route_valid), 2'b10);
    chk("long_hdr_west", port_of(1), int'(P_WEST));
    flit_read[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      flit_type[3:2] = (k == 0) ? T_HDR : T_BODY;
      tick();
      chk($sformatf("long_k%0d_valid", k), int'(route_valid), 2'b10);
      chk($sformatf("long_k%0d_port", k), port_of(1), int'(P_WEST));
    end
    flit_type[3:2] = T_TAIL;
    tick();
    chk("long_tail_valid", int'(route_valid), 0);
    chk("long_tail_port", port_of(1), 0);
    flit_read[1] = 1'b0;
    set_front(1, T_HDR, 2'd1, 2'd3);
    tick();
    chk("long_next_valid", int'(route_valid), 2'b10);
    chk("long_next_south", port_of(1), int'(P_SOUTH));
    flit_type[3:2] = T_TAIL; flit_read[1] = 1'b1;
    tick();
    chk("long_next_retired", int'(route_valid), 0);
    flit_read = '0; flit_valid = '0;

    // Body flit at the front of an IDLE VC
    set_front(0, T_BODY, 2'd0, 2'd0);
    flit_valid[0] = 1'b1;
    tick();
    chk("perr_pulse", int'(protocol_err), 2'b01);
    chk("perr_no_route", int'(route_valid), 0);
    tick();
    chk("perr_repeat", int'(protocol_err), 2'b01);
    flit_valid = '0;
    tick();
    chk("perr_clear", int'(protocol_err), 0);

    // Read on a VC that holds no route is ignored
    flit_type[1:0] = T_TAIL; flit_read[0] = 1'b1;
    tick();
    chk("stray_read_valid", int'(route_valid), 0);
    chk("stray_read_err", int'(protocol_err), 0);
    flit_read = '0;

    // Reset mid-packet drops the held route
    set_front(0, T_HDR, 2'd3, 2'd1);
    flit_valid[0] = 1'b1;
    tick();
    chk("midrst_routed", int'(route_valid), 2'b01);
    flit_read[0] = 1'b1;
    tick();
    flit_read = '0;
    flit_type[1:0] = T_BODY;
    rst_ni = 1'b0;
    tick();
    chk("midrst_valid", int'(route_valid), 0);
    chk("midrst_port", port_of(0), 0);
    rst_ni = 1'b1;
    tick();
    chk("midrst_body_err", int'(protocol_err), 2'b01);
    chk("midrst_body_noroute", int'(route_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
